// File: rtl/alu_result_display.sv
// alu_result_display
//   Output stage for the 8-bit ALU. Captures an 8-bit result plus the 4-bit
//   op select on a valid strobe and converts the result to decimal with a
//   sequential double-dabble (one shift per clock, 8 clocks per conversion).
//   It then time-multiplexes the Basys3 4-digit seven-segment display:
//   digit 3 shows the op code in hex, and digits 2..0 show the result in
//   decimal.
//
//   Optional build macro: SIGNED_DISPLAY_EN
//     When defined, result is treated as two's complement and its magnitude
//     is shown. Digit 3 shows '-' for negative results and is blank
//     otherwise. op_sel is still latched but is not displayed.
//
//   Parameters
//     REFRESH_DIV : clk cycles per digit slot (>= 2)
//     BLANK_LZ    : 1 = blank leading decimal zeros, 0 = always light 3 digits
//
//   Ports
//     clk     : system clock
//     rst_n   : asynchronous active-low reset
//     result  : ALU result to display
//     op_sel  : ALU op select, captured together with result
//     valid   : one-cycle capture strobe
//     busy    : high while a conversion is in progress
//     seg     : {g,f,e,d,c,b,a}, active-low
//     an      : digit anodes, active-low, an[0] = rightmost digit
module alu_result_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] result,
    input  logic [3:0] op_sel,
    input  logic       valid,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int RW = $clog2(REFRESH_DIV);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    op_cvt_q, op_cvt_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_result_q, pend_result_d;
    logic [3:0]    pend_op_q, pend_op_d;
    logic          busy_q, busy_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    op_q, op_d;
`ifdef SIGNED_DISPLAY_EN
    logic          neg_cvt_q, neg_cvt_d;
    logic          neg_q, neg_d;
`endif
    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic [11:0]   bcd_step;
    logic [7:0]    load_result;
    logic [3:0]    load_op;

    // Value actually fed to the converter: raw byte, or magnitude when signed.
    function automatic logic [7:0] magnitude(input logic [7:0] r);
`ifdef SIGNED_DISPLAY_EN
        // -128 negates to 8'h80, which reads as 128 unsigned.
        magnitude = r[7] ? (~r + 8'd1) : r;
`else
        magnitude = r;
`endif
    endfunction

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
    // the next binary bit in at the LSB.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic b);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        dabble_step = {adj[10:0], b};
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    // Conversion FSM, pending buffer and display registers.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        op_cvt_d      = op_cvt_q;
        pend_d        = pend_q;
        pend_result_d = pend_result_q;
        pend_op_d     = pend_op_q;
        busy_d        = busy_q;
        hund_d        = hund_q;
        tens_d        = tens_q;
        ones_d        = ones_q;
        op_d          = op_q;
`ifdef SIGNED_DISPLAY_EN
        neg_cvt_d     = neg_cvt_q;
        neg_d         = neg_q;
`endif
        bcd_step      = dabble_step(bcd_q, shift_q[7]);
        // A valid on the completion edge wins over older pending data.
        load_result   = valid ? result : pend_result_q;
        load_op       = valid ? op_sel : pend_op_q;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    shift_d   = magnitude(result);
                    op_cvt_d  = op_sel;
`ifdef SIGNED_DISPLAY_EN
                    neg_cvt_d = result[7];
`endif
                    bcd_d     = 12'd0;
                    cnt_d     = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = CONVERT;
                end
            end
            default: begin
                bcd_d   = bcd_step;
                shift_d = {shift_q[6:0], 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    hund_d = bcd_step[11:8];
                    tens_d = bcd_step[7:4];
                    ones_d = bcd_step[3:0];
                    op_d   = op_cvt_q;
`ifdef SIGNED_DISPLAY_EN
                    neg_d  = neg_cvt_q;
`endif
                    if (valid || pend_q) begin
                        // Restart straight away; busy stays high.
                        shift_d   = magnitude(load_result);
                        op_cvt_d  = load_op;
`ifdef SIGNED_DISPLAY_EN
                        neg_cvt_d = load_result[7];
`endif
                        bcd_d     = 12'd0;
                        cnt_d     = 3'd0;
                        pend_d    = 1'b0;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (valid) begin
                    pend_d        = 1'b1;
                    pend_result_d = result;
                    pend_op_d     = op_sel;
                end
            end
        endcase
    end

    // Scan: free-running, never touched by the conversion logic.
    always_comb begin
        refresh_d = refresh_q + RW'(1);
        digit_d   = digit_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = digit_q + 2'd1;
        end

        an_d = ~(4'b0001 << digit_q);
        case (digit_q)
            2'd0: seg_d = hex_glyph(ones_q);
            2'd1: seg_d = (BLANK_LZ != 0 && hund_q == 4'd0 && tens_q == 4'd0)
                          ? 7'h7F : hex_glyph(tens_q);
            2'd2: seg_d = (BLANK_LZ != 0 && hund_q == 4'd0) ? 7'h7F : hex_glyph(hund_q);
`ifdef SIGNED_DISPLAY_EN
            default: seg_d = neg_q ? 7'h3F : 7'h7F;
`else
            default: seg_d = hex_glyph(op_q);
`endif
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= 8'd0;
            bcd_q         <= 12'd0;
            cnt_q         <= 3'd0;
            op_cvt_q      <= 4'd0;
            pend_q        <= 1'b0;
            pend_result_q <= 8'd0;
            pend_op_q     <= 4'd0;
            busy_q        <= 1'b0;
            hund_q        <= 4'd0;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            op_q          <= 4'd0;
`ifdef SIGNED_DISPLAY_EN
            neg_cvt_q     <= 1'b0;
            neg_q         <= 1'b0;
`endif
            refresh_q     <= '0;
            digit_q       <= 2'd0;
            seg_q         <= 7'h7F;
            an_q          <= 4'hF;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            op_cvt_q      <= op_cvt_d;
            pend_q        <= pend_d;
            pend_result_q <= pend_result_d;
            pend_op_q     <= pend_op_d;
            busy_q        <= busy_d;
            hund_q        <= hund_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            op_q          <= op_d;
`ifdef SIGNED_DISPLAY_EN
            neg_cvt_q     <= neg_cvt_d;
            neg_q         <= neg_d;
`endif
            refresh_q     <= refresh_d;
            digit_q       <= digit_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Testbench for alu_result_display. Two instances (BLANK_LZ=1 and 0) share
// the stimulus; a behavioural model predicts busy/seg/an every cycle, and
// directed scans compare against hand-computed glyphs.
module tb_alu_result_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] result;
    logic [3:0] op_sel;
    logic       valid;
    logic       busy_a, busy_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    alu_result_display #(.REFRESH_DIV(RD), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .result(result), .op_sel(op_sel),
        .valid(valid), .busy(busy_a), .seg(seg_a), .an(an_a)
    );

    alu_result_display #(.REFRESH_DIV(RD), .BLANK_LZ(0)) u_dut_nlz (
        .clk(clk), .rst_n(rst_n), .result(result), .op_sel(op_sel),
        .valid(valid), .busy(busy_b), .seg(seg_b), .an(an_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[v & 15];
    endfunction

    function automatic int mag(input logic [7:0] r);
`ifdef SIGNED_DISPLAY_EN
        return r[7] ? 256 - int'(r) : int'(r);
`else
        return int'(r);
`endif
    endfunction

    // Glyph for one digit position given the displayed decimal value.
    function automatic logic [6:0] exp_seg(input int slot, input int val, input int op,
                                           input bit neg, input int blz);
        case (slot)
            0: return glyph(val % 10);
            1: return (blz != 0 && val < 10) ? 7'h7F : glyph((val / 10) % 10);
            2: return (blz != 0 && val < 100) ? 7'h7F : glyph(val / 100);
`ifdef SIGNED_DISPLAY_EN
            default: return neg ? 7'h3F : 7'h7F;
`else
            default: return glyph(op);
`endif
        endcase
    endfunction

    bit         m_busy, m_pend;
    int         m_left, m_tick;
    int         m_cur_val, m_cur_op, m_pend_val, m_pend_op;
    bit         m_cur_neg, m_pend_neg;
    int         m_disp_val, m_disp_op;
    bit         m_disp_neg;
    logic [6:0] m_seg_a, m_seg_b;
    logic [3:0] m_an;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_pend <= 0; m_left <= 0; m_tick <= 0;
            m_disp_val <= 0; m_disp_op <= 0; m_disp_neg <= 0;
            m_seg_a <= 7'h7F; m_seg_b <= 7'h7F; m_an <= 4'hF;
        end else begin
            m_tick  <= m_tick + 1;
            m_an    <= ~(4'b0001 << ((m_tick / RD) % 4));
            m_seg_a <= exp_seg((m_tick / RD) % 4, m_disp_val, m_disp_op, m_disp_neg, 1);
            m_seg_b <= exp_seg((m_tick / RD) % 4, m_disp_val, m_disp_op, m_disp_neg, 0);
            if (!m_busy) begin
                if (valid) begin
                    m_busy <= 1; m_left <= 8;
                    m_cur_val <= mag(result); m_cur_op <= int'(op_sel); m_cur_neg <= result[7];
                end
            end else if (m_left == 1) begin
                m_disp_val <= m_cur_val; m_disp_op <= m_cur_op; m_disp_neg <= m_cur_neg;
                if (valid) begin
                    m_left <= 8; m_pend <= 0;
                    m_cur_val <= mag(result); m_cur_op <= int'(op_sel); m_cur_neg <= result[7];
                end else if (m_pend) begin
                    m_left <= 8; m_pend <= 0;
                    m_cur_val <= m_pend_val; m_cur_op <= m_pend_op; m_cur_neg <= m_pend_neg;
                end else begin
                    m_busy <= 0;
                end
            end else begin
                m_left <= m_left - 1;
                if (valid) begin
                    m_pend <= 1;
                    m_pend_val <= mag(result); m_pend_op <= int'(op_sel); m_pend_neg <= result[7];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_a", busy_a, m_busy);
            chk("busy_b", busy_b, m_busy);
            chk("an_a", an_a, m_an);
            chk("an_b", an_b, m_an);
            chk("seg_a", seg_a, m_seg_a);
            chk("seg_b", seg_b, m_seg_b);
        end
    end

    // Length of the most recent busy-high run, in cycles.
    int busy_run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (busy_a) busy_run <= busy_run + 1;
        else begin
            if (busy_run != 0) last_run <= busy_run;
            busy_run <= 0;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic pulse_valid(input logic [7:0] r, input logic [3:0] op);
        @(negedge clk);
        result = r; op_sel = op; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_a && n < 100) begin @(negedge clk); n++; end
        if (busy_a) chk("idle_timeout", busy_a, 1'b0);
        @(negedge clk);
    endtask

    // Walk digits 0..3 and compare each glyph; ex = {d3,d2,d1,d0}.
    task automatic scan_lit(input string name, input logic [27:0] ea, input logic [27:0] eb);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] tgt;
            int n, run;
            tgt = ~(4'b0001 << d);
            n = 0;
            while (an_a !== tgt && n < 64) begin @(negedge clk); n++; end
            if (an_a !== tgt) begin
                chk($sformatf("%s_an%0d_timeout", name, d), an_a, tgt);
            end else begin
                chk($sformatf("%s_a_d%0d", name, d), seg_a, ea[7*d +: 7]);
                chk($sformatf("%s_b_d%0d", name, d), seg_b, eb[7*d +: 7]);
                run = 0;
                while (an_a === tgt && run < 16) begin @(negedge clk); run++; end
                if (d > 0) chk($sformatf("%s_slot%0d_len", name, d), run, RD);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; valid = 1'b0; result = 8'd0; op_sel = 4'd0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;

        // Model pinning against hand-computed glyphs.
        chk("model_237_d0", exp_seg(0, 237, 10, 0, 1), 7'h78);
        chk("model_5_d1_blank", exp_seg(1, 5, 0, 0, 1), 7'h7F);
        chk("model_5_d2_zero", exp_seg(2, 5, 0, 0, 0), 7'h40);

        repeat (3) @(negedge clk);
        chk("rst_seg", seg_a, 7'h7F);
        chk("rst_an", an_a, 4'hF);
        chk("rst_busy", busy_a, 1'b0);
        rst_n = 1'b1;
`ifdef SIGNED_DISPLAY_EN
        scan_lit("reset", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h40, 7'h40, 7'h40});
`else
        scan_lit("reset", {7'h40, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40});
`endif

        // 237, op A
        pulse_valid(8'd237, 4'hA);
        wait_idle();
        chk("busy_len_237", last_run, 8);
`ifdef SIGNED_DISPLAY_EN
        scan_lit("v237", {7'h3F, 7'h7F, 7'h79, 7'h10}, {7'h3F, 7'h40, 7'h79, 7'h10});
`else
        scan_lit("v237", {7'h08, 7'h24, 7'h30, 7'h78}, {7'h08, 7'h24, 7'h30, 7'h78});
`endif

        // 5, op 3: leading zeros
        pulse_valid(8'd5, 4'h3);
        wait_idle();
`ifdef SIGNED_DISPLAY_EN
        scan_lit("v5", {7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h7F, 7'h40, 7'h40, 7'h12});
`else
        scan_lit("v5", {7'h30, 7'h7F, 7'h7F, 7'h12}, {7'h30, 7'h40, 7'h40, 7'h12});
`endif

        // Back-to-back: 10 at c0, 99 at c3, 200 at c5
        @(negedge clk);
        result = 8'd10; op_sel = 4'h1; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        @(negedge clk);
        @(negedge clk); result = 8'd99; op_sel = 4'h2; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        @(negedge clk); result = 8'd200; op_sel = 4'h4; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        wait_idle();
        chk("busy_len_b2b", last_run, 16);
`ifdef SIGNED_DISPLAY_EN
        scan_lit("v200", {7'h3F, 7'h7F, 7'h12, 7'h02}, {7'h3F, 7'h40, 7'h12, 7'h02});
`else
        scan_lit("v200", {7'h19, 7'h24, 7'h40, 7'h40}, {7'h19, 7'h24, 7'h40, 7'h40});
`endif

        // valid exactly on the completion edge restarts with the new data
        pulse_valid(8'd42, 4'h6);
        repeat (7) @(negedge clk);
        result = 8'd77; op_sel = 4'hC; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        wait_idle();
        chk("busy_len_edge", last_run, 16);
        repeat (20) @(negedge clk);

        // Reset mid-conversion of 255
        pulse_valid(8'd255, 4'hF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_seg", seg_a, 7'h7F);
        chk("midrst_an", an_a, 4'hF);
        chk("midrst_busy", busy_a, 1'b0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_still_idle", busy_a, 1'b0);
`ifdef SIGNED_DISPLAY_EN
        scan_lit("midrst", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h40, 7'h40, 7'h40});
`else
        scan_lit("midrst", {7'h40, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40});
`endif

`ifdef SIGNED_DISPLAY_EN
        pulse_valid(8'h80, 4'h0);
        wait_idle();
        scan_lit("s80", {7'h3F, 7'h79, 7'h24, 7'h00}, {7'h3F, 7'h79, 7'h24, 7'h00});
        pulse_valid(8'hFF, 4'h0);
        wait_idle();
        scan_lit("sFF", {7'h3F, 7'h7F, 7'h7F, 7'h79}, {7'h3F, 7'h40, 7'h40, 7'h79});
`endif

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
